// File: rtl/tiny32_timer.sv
// tiny32_timer: memory-mapped timer for the Tiny32 SoC.
// Programmable prescaler feeding a counter with compare match, a sticky FLAG
// and a level interrupt cleared by irq_ack or a STATUS write.
// Optional capture unit (synchronised capture_in, CAPTURE register, CAPFLAG)
// is built only when the macro TIMER_CAPTURE_EN is defined.
module tiny32_timer #(
    parameter int unsigned TIMER_BITS = 32,
    parameter int unsigned PRESC_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        wr,
    input  logic [2:0]  address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        irq,
    input  logic        irq_ack,
    input  logic        capture_in
);

    localparam int unsigned BUS_BITS   = 32;
    localparam int unsigned PRESC_LSB  = 8;
    localparam logic [2:0]  ADDR_CTRL    = 3'd0;
    localparam logic [2:0]  ADDR_COUNTER = 3'd1;
    localparam logic [2:0]  ADDR_COMPARE = 3'd2;
    localparam logic [2:0]  ADDR_STATUS  = 3'd3;
    localparam logic [2:0]  ADDR_CAPTURE = 3'd4;

    // Bus interface registers
    logic                  r_ack;
    logic [BUS_BITS-1:0]   r_rdata;

    // Timer registers
    logic                  r_en;
    logic                  r_autoreload;
    logic                  r_irqen;
    logic [PRESC_BITS-1:0] r_presc;
    logic [PRESC_BITS-1:0] r_presc_cnt;
    logic [TIMER_BITS-1:0] r_counter;
    logic [TIMER_BITS-1:0] r_compare;
    logic                  r_flag;

    // Decoded access strobes
    logic                  w_access;
    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_counter;
    logic                  w_wr_compare;
    logic                  w_wr_status;

    // Timer datapath
    logic                  w_presc_hit;
    logic                  w_tick;
    logic                  w_match;
    logic                  w_flag_set;
    logic                  w_flag_clr;
    logic [TIMER_BITS-1:0] w_counter_nxt;
    logic                  w_en_nxt;
    logic [PRESC_BITS-1:0] w_presc_cnt_nxt;
    logic [BUS_BITS-1:0]   w_rdata_mux;

    // Capture view seen by the read mux and irq (constant 0 without the unit)
    logic                  w_capflag;
    logic [TIMER_BITS-1:0] w_capture;

    // Bits of wdata above TIMER_BITS, and capture_in without the unit, are don't-care
    logic                  w_unused;
    assign w_unused = ^{wdata, capture_in};

    // An access is accepted only when no ack is pending
    assign w_access     = sel & ~r_ack;
    assign w_wr         = w_access & wr;
    assign w_wr_ctrl    = w_wr & (address == ADDR_CTRL);
    assign w_wr_counter = w_wr & (address == ADDR_COUNTER);
    assign w_wr_compare = w_wr & (address == ADDR_COMPARE);
    assign w_wr_status  = w_wr & (address == ADDR_STATUS);

    assign w_presc_hit = (r_presc_cnt == r_presc);
    assign w_tick      = r_en & w_presc_hit;
    assign w_match     = (r_counter == r_compare);

    // Match sets FLAG and beats any simultaneous clear
    assign w_flag_set  = w_tick & w_match;
    assign w_flag_clr  = irq_ack | (w_wr_status & wdata[0]);

    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign irq   = (r_flag | w_capflag) & r_irqen;

    // Next counter, enable and prescaler count; CTRL/COUNTER writes override the tick
    always_comb begin
        w_counter_nxt   = r_counter;
        w_en_nxt        = r_en;
        w_presc_cnt_nxt = r_presc_cnt;
        if (r_en) begin
            w_presc_cnt_nxt = w_presc_hit ? '0 : r_presc_cnt + PRESC_BITS'(1);
        end
        if (w_tick && !w_wr_ctrl && !w_wr_counter) begin
            if (w_match) begin
                if (r_autoreload) begin
                    w_counter_nxt = '0;
                end else begin
                    w_en_nxt = 1'b0;
                end
            end else begin
                w_counter_nxt = r_counter + TIMER_BITS'(1);
            end
        end
        if (w_wr_ctrl) begin
            w_en_nxt = wdata[0];
        end
        if (w_wr_counter) begin
            w_counter_nxt   = wdata[TIMER_BITS-1:0];
            w_presc_cnt_nxt = '0;
        end
    end

    // Register read mux; unmapped bits and addresses read as zero
    always_comb begin
        w_rdata_mux = '0;
        case (address)
            ADDR_CTRL: begin
                w_rdata_mux[0] = r_en;
                w_rdata_mux[1] = r_autoreload;
                w_rdata_mux[2] = r_irqen;
                w_rdata_mux[PRESC_LSB +: PRESC_BITS] = r_presc;
            end
            ADDR_COUNTER: w_rdata_mux = BUS_BITS'(r_counter);
            ADDR_COMPARE: w_rdata_mux = BUS_BITS'(r_compare);
            ADDR_STATUS: begin
                w_rdata_mux[0] = r_flag;
                w_rdata_mux[1] = w_capflag;
            end
            ADDR_CAPTURE: w_rdata_mux = BUS_BITS'(w_capture);
            default: w_rdata_mux = '0;
        endcase
    end

    // Bus handshake: one-cycle ack after each accepted access, read data registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_access;
            if (w_access) begin
                r_rdata <= wr ? '0 : w_rdata_mux;
            end
        end
    end

    // CTRL fields; EN can also be cleared by a one-shot match
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_irqen      <= 1'b0;
            r_presc      <= '0;
        end else begin
            r_en <= w_en_nxt;
            if (w_wr_ctrl) begin
                r_autoreload <= wdata[1];
                r_irqen      <= wdata[2];
                r_presc      <= wdata[PRESC_LSB +: PRESC_BITS];
            end
        end
    end

    // Counter and prescaler count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter   <= '0;
            r_presc_cnt <= '0;
        end else begin
            r_counter   <= w_counter_nxt;
            r_presc_cnt <= w_presc_cnt_nxt;
        end
    end

    // Compare register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_compare <= '1;
        end else if (w_wr_compare) begin
            r_compare <= wdata[TIMER_BITS-1:0];
        end
    end

    // Match flag with set-over-clear priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag <= 1'b0;
        end else begin
            r_flag <= w_flag_set | (r_flag & ~w_flag_clr);
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic                  r_cap_sync1;
    logic                  r_cap_sync2;
    logic                  r_cap_prev;
    logic [TIMER_BITS-1:0] r_capture;
    logic                  r_capflag;
    logic                  w_cap_rise;
    logic                  w_capflag_clr;

    assign w_cap_rise    = r_cap_sync2 & ~r_cap_prev;
    assign w_capflag_clr = irq_ack | (w_wr_status & wdata[1]);
    assign w_capflag     = r_capflag;
    assign w_capture     = r_capture;

    // Synchronise capture_in, latch COUNTER on its rising edge, set-over-clear CAPFLAG
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap_sync1 <= 1'b0;
            r_cap_sync2 <= 1'b0;
            r_cap_prev  <= 1'b0;
            r_capture   <= '0;
            r_capflag   <= 1'b0;
        end else begin
            r_cap_sync1 <= capture_in;
            r_cap_sync2 <= r_cap_sync1;
            r_cap_prev  <= r_cap_sync2;
            if (w_cap_rise) begin
                r_capture <= r_counter;
            end
            r_capflag <= w_cap_rise | (r_capflag & ~w_capflag_clr);
        end
    end
`else
    assign w_capflag = 1'b0;
    assign w_capture = '0;
`endif

endmodule
